// File: rtl/seven_seg_scan.sv
// Scans a 4-digit common-anode seven-segment display, one digit per rising edge of div_clk.
// Latency: div_clk rise -> tick 2-3 clk; tick -> DEAD_CYCLES blank cycles -> next digit shown.
// Backpressure: none; ticks that arrive while blanking are dropped, not queued.
module seven_seg_scan #(
  parameter int DEAD_CYCLES = 16,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [0:0]  ST_BLANK  = 1'b0;
  localparam logic [0:0]  ST_SHOW   = 1'b1;
  localparam logic [11:0] DEAD_LAST = 12'(DEAD_CYCLES - 1);

  logic        s1, s2, s3;
  logic        tick;
  logic [0:0]  state, state_nxt;
  logic [11:0] dead_cnt, dead_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] shadow_digits;
  logic [3:0]  shadow_dp;
  logic        snap_done;
  logic        snap;
  logic [3:0]  nib_sel;
  logic        lz_blank;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Rising edge of the synchronised divided wave; one pulse per div_clk period.
  assign tick = s2 & ~s3;

  // Scan FSM: count out the dead time in BLANK, advance the digit on a tick in SHOW.
  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    idx_nxt   = idx;
    snap      = ~snap_done;
    case (state)
      ST_BLANK: begin
        if (dead_cnt == DEAD_LAST) begin
          state_nxt = ST_SHOW;
          dead_nxt  = 12'd0;
        end else begin
          dead_nxt = dead_cnt + 12'd1;
        end
      end
      default: begin
        if (tick) begin
          idx_nxt   = idx + 2'd1;
          state_nxt = ST_BLANK;
          dead_nxt  = 12'd0;
          // Leaving digit 3 starts a new frame: latch a fresh coherent value.
          if (idx_nxt == 2'd0) begin
            snap = 1'b1;
          end
        end
      end
    endcase
  end

  // Leading-zero blanking judged on the frozen frame value, never on live inputs.
  always_comb begin
    lz_blank = 1'b0;
    if (LZ_SUPPRESS) begin
      case (idx_nxt)
        2'd3:    lz_blank = (shadow_digits[15:12] == 4'h0);
        2'd2:    lz_blank = (shadow_digits[15:8] == 8'h00);
        2'd1:    lz_blank = (shadow_digits[15:4] == 12'h000);
        default: lz_blank = 1'b0;
      endcase
    end
  end

  // Next output values, computed for the upcoming state so the outputs can be registered.
  always_comb begin
    nib_sel = shadow_digits[{idx_nxt, 2'b00} +: 4];
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    if (state_nxt == ST_SHOW) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = lz_blank ? 7'b1111111 : hex_to_seg(nib_sel);
      dp_nxt  = ~shadow_dp[idx_nxt];
    end
  end

  // All state: synchroniser, FSM, frame snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      state         <= ST_BLANK;
      dead_cnt      <= 12'd0;
      idx           <= 2'd0;
      shadow_digits <= 16'h0000;
      shadow_dp     <= 4'h0;
      snap_done     <= 1'b0;
      an            <= 4'b1111;
      seg           <= 7'b1111111;
      dp            <= 1'b1;
    end else begin
      s1        <= div_clk;
      s2        <= s1;
      s3        <= s2;
      state     <= state_nxt;
      dead_cnt  <= dead_nxt;
      idx       <= idx_nxt;
      snap_done <= 1'b1;
      if (snap) begin
        shadow_digits <= digits;
        shadow_dp     <= dp_en;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (leading-zero suppression on and off) share stimulus.
// Each div_clk rise pushes the expected next digit; the monitor pops it when a digit appears.
// Also checks the blank gap before every shown digit and that nothing extra is shown.
module tb_seven_seg_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nlz;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_clk;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic [3:0]  an, an0;
  logic [6:0]  seg, seg0;
  logic        dp, dp0;

  int vectors = 0;
  int errors  = 0;

  exp_t        sb[$];
  exp_t        cur;
  int          blank_cnt = 0;
  bit          showing = 1'b0;

  logic [1:0]  exp_idx;
  logic [15:0] frame;
  logic [3:0]  fdp;

  always #5 clk = ~clk;

  seven_seg_scan #(.DEAD_CYCLES(16), .LZ_SUPPRESS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk), .digits(digits), .dp_en(dp_en),
    .an(an), .seg(seg), .dp(dp)
  );

  seven_seg_scan #(.DEAD_CYCLES(16), .LZ_SUPPRESS(1'b0)) u_dut_nlz (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk), .digits(digits), .dp_en(dp_en),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] i, input logic [15:0] f, input logic [3:0] d);
    exp_t       e;
    logic [3:0] nib;
    logic       blank;
    nib   = f[{i, 2'b00} +: 4];
    blank = (i == 2'd3 && f[15:12] == 4'h0) || (i == 2'd2 && f[15:8] == 8'h00) ||
            (i == 2'd1 && f[15:4] == 12'h000);
    e.an      = 4'hF;
    e.an[i]   = 1'b0;
    e.seg_nlz = seg_of(nib);
    e.seg     = blank ? 7'h7F : seg_of(nib);
    e.dp      = ~d[i];
    return e;
  endfunction

  // One div_clk period; the rising edge should advance the display by one digit.
  task automatic do_tick(input int high, input int low);
    @(posedge clk);
    #2 div_clk = 1'b1;
    exp_idx = exp_idx + 2'd1;
    if (exp_idx == 2'd0) begin
      frame = digits;
      fdp   = dp_en;
    end
    sb.push_back(mk_exp(exp_idx, frame, fdp));
    repeat (high) @(posedge clk);
    #2 div_clk = 1'b0;
    repeat (low) @(posedge clk);
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] p);
    @(posedge clk);
    #2 digits = d;
    dp_en = p;
  endtask

  // Monitor: every new digit must match the next queued expectation after exactly 16 blank cycles.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      blank_cnt = 0;
      showing   = 1'b0;
    end else if (an == 4'hF) begin
      blank_cnt++;
      showing = 1'b0;
    end else if (!showing) begin
      showing = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_show", 32'(an), 32'hF);
      end else begin
        cur = sb.pop_front();
        chk("an", 32'(an), 32'(cur.an));
        chk("seg", 32'(seg), 32'(cur.seg));
        chk("dp", 32'(dp), 32'(cur.dp));
        chk("an_nlz", 32'(an0), 32'(cur.an));
        chk("seg_nlz", 32'(seg0), 32'(cur.seg_nlz));
        chk("blank_len", 32'(blank_cnt), 32'd16);
      end
      blank_cnt = 0;
    end else if ({an, seg, dp} != {cur.an, cur.seg, cur.dp}) begin
      chk("stable", 32'({an, seg, dp}), 32'({cur.an, cur.seg, cur.dp}));
    end
  end

  initial begin
    rst_n   = 1'b0;
    div_clk = 1'b0;
    digits  = 16'h1234;
    dp_en   = 4'b0100;
    exp_idx = 2'd0;
    frame   = 16'h0;
    fdp     = 4'h0;

    // Reset with div_clk toggling.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2 div_clk = ~div_clk;
    end
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_an_nlz", 32'(an0), 32'hF);

    @(posedge clk);
    #2 rst_n = 1'b1;
    div_clk = 1'b0;
    exp_idx = 2'd0;
    frame   = digits;
    fdp     = dp_en;
    sb.push_back(mk_exp(exp_idx, frame, fdp));
    repeat (40) @(posedge clk);

    // Full scan of 1234, wrapping back to digit 0.
    for (int i = 0; i < 4; i++) do_tick(50, 50);

    // Change the value mid-frame while digit 1 is shown.
    do_tick(50, 50);
    set_in(16'h5678, 4'b0100);
    for (int i = 0; i < 6; i++) do_tick(50, 50);

    // Leading zeros, with a decimal point on a blanked digit.
    set_in(16'h0070, 4'b1000);
    for (int i = 0; i < 4; i++) do_tick(50, 50);

    // All F.
    set_in(16'hFFFF, 4'b0001);
    for (int i = 0; i < 4; i++) do_tick(50, 50);

    // div_clk held high for 1000 cycles: only the single rising edge counts.
    do_tick(1000, 50);

    // Extra div_clk pulse landing inside the blank window is dropped.
    @(posedge clk);
    #2 div_clk = 1'b1;
    exp_idx = exp_idx + 2'd1;
    if (exp_idx == 2'd0) begin
      frame = digits;
      fdp   = dp_en;
    end
    sb.push_back(mk_exp(exp_idx, frame, fdp));
    repeat (6) @(posedge clk);
    #2 div_clk = 1'b0;
    repeat (4) @(posedge clk);
    #2 div_clk = 1'b1;
    repeat (4) @(posedge clk);
    #2 div_clk = 1'b0;
    repeat (90) @(posedge clk);

    // Reach digit 2, then reset mid-scan.
    for (int i = 0; i < 4 && exp_idx != 2'd2; i++) do_tick(50, 50);
    @(negedge clk);
    chk("an_pre_rst", 32'(an), 32'hB);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_dp", 32'(dp), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    exp_idx = 2'd0;
    frame   = digits;
    fdp     = dp_en;
    sb.push_back(mk_exp(exp_idx, frame, fdp));
    repeat (40) @(posedge clk);
    do_tick(50, 50);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
